// File: rtl/bcd_tick_counter.sv
// Two-digit BCD counter advanced by rising edges of tick_in while running.
// Define TICK_SYNC_EN to pass tick_in through a two-flop synchronizer first.
//
// state | meaning
// IDLE  | cleared, waiting for start
// RUN   | counting tick_in rising edges
// PAUSE | count held, waiting for start to resume
module bcd_tick_counter #(
    parameter int TENS_MAX = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       running,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] TENS_TOP = 4'(TENS_MAX);

    state_t     state;
    state_t     state_nxt;
    logic       tick_s;
    logic       tick_prev;
    logic       tick_evt;
    logic       advance;
    logic [3:0] ones_nxt;
    logic [3:0] tens_nxt;
    logic       wrap_nxt;
    logic       running_nxt;

`ifdef TICK_SYNC_EN
    logic tick_sync1;
    logic tick_sync2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_sync1 <= 1'b0;
            tick_sync2 <= 1'b0;
        end else begin
            tick_sync1 <= tick_in;
            tick_sync2 <= tick_sync1;
        end
    end

    assign tick_s = tick_sync2;
`else
    assign tick_s = tick_in;
`endif

    // tick_prev samples in every state so an edge seen while idle is not replayed later
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_prev <= 1'b0;
        end else begin
            tick_prev <= tick_s;
        end
    end

    assign tick_evt = tick_s & ~tick_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ones    <= 4'd0;
            tens    <= 4'd0;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ones    <= ones_nxt;
            tens    <= tens_nxt;
            running <= running_nxt;
            wrap    <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && !stop) state_nxt = RUN;
                RUN:     if (stop && !start) state_nxt = PAUSE;
                PAUSE:   if (start && !stop) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // advance depends on the current state, so an edge landing on RUN->PAUSE still counts
    always_comb begin
        advance     = tick_evt && (state == RUN);
        ones_nxt    = ones;
        tens_nxt    = tens;
        wrap_nxt    = 1'b0;
        running_nxt = (state_nxt == RUN);
        if (clear) begin
            ones_nxt = 4'd0;
            tens_nxt = 4'd0;
        end else if (advance) begin
            if (ones < 4'd9) begin
                ones_nxt = ones + 4'd1;
            end else if (tens < TENS_TOP) begin
                ones_nxt = 4'd0;
                tens_nxt = tens + 4'd1;
            end else begin
                ones_nxt = 4'd0;
                tens_nxt = 4'd0;
                wrap_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter: a count-level model checked every cycle
// plus literal expectations at the scenario milestones.
module tb_bcd_tick_counter;

    localparam int TM = 5;
`ifdef TICK_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       running;
    logic       wrap;

    int tests = 0;
    int fails = 0;
    int wrap_seen = 0;
    bit chk_en = 0;

    bcd_tick_counter #(.TENS_MAX(TM)) dut (
        .clock  (clock),
        .reset  (reset),
        .tick_in(tick_in),
        .start  (start),
        .stop   (stop),
        .clear  (clear),
        .ones   (ones),
        .tens   (tens),
        .running(running),
        .wrap   (wrap)
    );

    always #5 clock = ~clock;

    // Model: count as a plain integer 0..TM*10+9, state 0=idle 1=run 2=pause,
    // tick history delayed by D cycles to represent the optional synchronizer.
    int           mcount = 0;
    int           mstate = 0;
    bit           mwrap = 0;
    logic [D:0]   hist = '0;
    logic [D+1:0] chain;
    logic         m_evt;
    logic         m_adv;

    assign chain = {hist, tick_in};
    assign m_evt = chain[D] & ~chain[D+1];
    assign m_adv = m_evt && (mstate == 1) && !clear;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcount <= 0;
            mstate <= 0;
            mwrap  <= 0;
            hist   <= '0;
        end else begin
            hist  <= chain[D:0];
            mwrap <= m_adv && (mcount == TM*10 + 9);
            if (clear) begin
                mcount <= 0;
                mstate <= 0;
            end else begin
                if (m_adv) mcount <= (mcount == TM*10 + 9) ? 0 : mcount + 1;
                if (start && !stop && mstate != 1) mstate <= 1;
                else if (stop && !start && mstate == 1) mstate <= 2;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_ones", int'(ones), mcount % 10);
            check("cyc_tens", int'(tens), mcount / 10);
            check("cyc_running", int'(running), (mstate == 1) ? 1 : 0);
            check("cyc_wrap", int'(wrap), int'(mwrap));
            if (wrap) wrap_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic rise(input int n);
        repeat (n) begin
            tick_in = 1'b1;
            cyc(3);
            tick_in = 1'b0;
            cyc(3);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(1);
    endtask

    task automatic check_cnt(input string name, input int t, input int o, input int r);
        #1;
        check({name, "_tens"}, int'(tens), t);
        check({name, "_ones"}, int'(ones), o);
        check({name, "_running"}, int'(running), r);
    endtask

    initial begin
        #3 reset = 1'b0;
        #1 chk_en = 1;
        check("rst_wrap", int'(wrap), 0);
        check_cnt("rst", 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        cyc(1);

        rise(5);
        check_cnt("idle_rises", 0, 0, 0);

        pulse_start();
        rise(10);
        check_cnt("ten_rises", 1, 0, 1);

        rise(48);
        check_cnt("at58", 5, 8, 1);
        wrap_seen = 0;
        rise(1);
        check_cnt("at59", 5, 9, 1);
        check("wrap_before", wrap_seen, 0);
        rise(1);
        check_cnt("rollover", 0, 0, 1);
        check("wrap_once", wrap_seen, 1);

        rise(23);
        pulse_stop();
        rise(4);
        check_cnt("paused23", 2, 3, 0);
        pulse_start();
        rise(1);
        check_cnt("resume24", 2, 4, 1);

        rise(13);
        check_cnt("at37", 3, 7, 1);
        clear = 1'b1;
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        clear = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        check_cnt("clear", 0, 0, 0);

        cyc(1);
        pulse_start();
        rise(41);
        check_cnt("at41", 4, 1, 1);
        #2 reset = 1'b0;
        #1 check("async_rst_wrap", int'(wrap), 0);
        check_cnt("async_rst", 0, 0, 0);
        tick_in = 1'b1;
        cyc(2);
        reset = 1'b1;
        cyc(4);
        check_cnt("tick_high_release", 0, 0, 0);
        pulse_start();
        cyc(3);
        check_cnt("start_tick_high", 0, 0, 1);
        tick_in = 1'b0;
        cyc(4);

        tick_in = 1'b1;
        cyc(20);
        tick_in = 1'b0;
        cyc(4);
        check_cnt("held_high", 0, 1, 1);

        start = 1'b1;
        stop  = 1'b1;
        cyc(2);
        start = 1'b0;
        stop  = 1'b0;
        cyc(1);
        check_cnt("start_stop_run", 0, 1, 1);

        tick_in = 1'b1;
        stop    = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(3);
        tick_in = 1'b0;
        cyc(3);
        check_cnt("evt_on_stop", 0, (D == 0) ? 2 : 1, 0);

        tick_in = 1'b1;
        start   = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        tick_in = 1'b0;
        cyc(3);
        check_cnt("evt_on_resume", 0, 2, 1);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_tick_counter.md
BCD_TICK_COUNTER -- requirements
Module: bcd_tick_counter

Interface
REQ-001 Parameter: TENS_MAX, default 5, value of the tens digit at which the count wraps (legal range 1..9).
REQ-002 Port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: tick_in  input  1  divided-clock level from the upstream mod-6 divider; each rising edge is one count event.
REQ-005 Port: start  input  1  run request, sampled each clock.
REQ-006 Port: stop  input  1  pause request, sampled each clock.
REQ-007 Port: clear  input  1  synchronous clear to IDLE/00.
REQ-008 Port: ones  output  4  BCD ones digit, 0..9.
REQ-009 Port: tens  output  4  BCD tens digit, 0..TENS_MAX.
REQ-010 Port: running  output  1  high while the FSM is in RUN.
REQ-011 Port: wrap  output  1  one-cycle pulse on rollover from TENS_MAX9 to 00.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE. All outputs SHALL be registered.
REQ-013 Transitions: IDLE -start-> RUN; RUN -stop-> PAUSE; PAUSE -start-> RUN; otherwise the FSM holds state.
REQ-014 When start and stop are both high in the same cycle, the state SHALL be unchanged.
REQ-015 Clear SHALL have priority over start and stop. Clear SHALL force IDLE and ones=0, tens=0, wrap=0 at the next edge, from any state.
REQ-016 A tick_prev register SHALL sample the (optionally synchronized) tick_in every cycle, in every state.
REQ-017 An event SHALL be detected when the sampled tick is 1 and tick_prev is 0.
REQ-018 The count SHALL advance only when an event is detected and the state is RUN. Events in IDLE or PAUSE SHALL be discarded, not queued.
REQ-019 Advance rule, ones < 9: ones+1, tens unchanged.
REQ-020 Advance rule, ones = 9 and tens < TENS_MAX: ones=0, tens+1.
REQ-021 Advance rule, ones = 9 and tens = TENS_MAX: ones=0, tens=0, and wrap=1 for exactly the following cycle.
REQ-022 Wrap SHALL be 0 in every cycle that does not immediately follow a rollover.
REQ-023 Latency without synchronizer: the count SHALL update at the first clock edge that samples tick_in=1 while tick_prev=0.
REQ-024 A tick_in level held high for many cycles SHALL produce exactly one advance.
REQ-025 An event coinciding with the RUN->PAUSE transition (stop high) SHALL still advance, because the state at that edge is RUN.
REQ-026 An event coinciding with the PAUSE->RUN transition SHALL NOT advance.
REQ-027 The digits SHALL never hold a non-BCD value or a tens value above TENS_MAX.

Reset
REQ-028 When reset is low, the block SHALL immediately (asynchronously) drive state=IDLE, ones=0, tens=0, running=0 and wrap=0, and clear tick_prev and any synchronizer flops.
REQ-029 Reset asserted mid-count SHALL discard the count; the block SHALL remain in IDLE after release until start.
REQ-030 A tick_in that is high at reset release SHALL NOT produce an advance, because the state is IDLE.

Configuration
REQ-031 Macro TICK_SYNC_EN defined: tick_in SHALL pass through a two-flop synchronizer before tick_prev/edge detect, adding exactly 2 cycles of latency.
REQ-032 Macro TICK_SYNC_EN undefined: tick_in SHALL feed edge detect directly, with the latency of REQ-023; ports and all other behaviour are identical.

Verification
REQ-033 Reset low, then release, with no start -> ones=0, tens=0, running=0, wrap=0; 5 tick_in rises cause no change.
REQ-034 Start pulse, then 10 tick_in rises -> tens=1, ones=0, running=1; with TICK_SYNC_EN, each update lags its rise by 2 extra cycles.
REQ-035 From count 58 in RUN, 2 rises -> 59 then 00; wrap=1 for exactly one cycle after 59->00, otherwise 0.
REQ-036 At count 23, stop; 4 rises -> count held at 23, running=0; start, then 1 rise -> 24.
REQ-037 Clear, start and stop all high at count 37 in RUN -> next cycle IDLE, count 00; reset low mid-count 41 -> immediate 00, IDLE.
REQ-038 tick_in held high for 20 cycles in RUN -> exactly one advance; start and stop high together in RUN -> state remains RUN.
